// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous
// square wave (sig_in) in units of clk cycles.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   en         in   measurement enable; low forces IDLE and clears status
//   sig_in     in   signal under measurement, asynchronous to clk
//   period     out  last rising-to-rising distance (clk cycles)
//   high_time  out  high time belonging to the last published period
//   meas_valid out  one-cycle pulse when period/high_time update
//   timeout    out  sticky: no rising edge within TIMEOUT cycles
//   locked     out  at least one full period measured since last IDLE
module clk_period_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic             sync_1;
    logic             sync_2;
    logic             sync_prev;
    logic             rise_c;
    logic             fall_c;

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic             publish_c;
    logic             expire_c;

    // cnt holds the number of cycles elapsed since the last detected rising
    // edge (or since entering ARM), so an edge at N+P sees cnt == P.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_lat;
    logic             got_fall;

    // Edge detection on the synchronized value and its previous sample.
    assign rise_c = sync_2 & ~sync_prev;
    assign fall_c = ~sync_2 & sync_prev;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and control strobes; an edge wins over an expiring count.
    always_comb begin
        state_d   = state;
        publish_c = 1'b0;
        expire_c  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise_c) begin
                        state_d = ST_MEAS;
                    end else if (cnt == TO_CNT) begin
                        expire_c = 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (rise_c) begin
                        publish_c = 1'b1;
                    end else if (cnt == TO_CNT) begin
                        expire_c = 1'b1;
                        state_d  = ST_ARM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Synchronizer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_prev  <= 1'b0;
            cnt        <= '0;
            high_lat   <= '0;
            got_fall   <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            sync_1     <= sig_in;
            sync_2     <= sync_1;
            sync_prev  <= sync_2;
            meas_valid <= publish_c;
            if (!en) begin
                // timeout can only be set while enabled, so clearing it for
                // as long as en is low is the same as clearing on the fall.
                cnt      <= '0;
                got_fall <= 1'b0;
                locked   <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                case (state)
                    ST_ARM: begin
                        if (rise_c) begin
                            cnt      <= ONE;
                            got_fall <= 1'b0;
                        end else if (expire_c) begin
                            cnt     <= '0;
                            timeout <= 1'b1;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    ST_MEAS: begin
                        if (publish_c) begin
                            period    <= cnt;
                            // No falling edge seen: report the full period.
                            high_time <= got_fall ? high_lat : cnt;
                            locked    <= 1'b1;
                            cnt       <= ONE;
                            got_fall  <= 1'b0;
                        end else if (expire_c) begin
                            timeout  <= 1'b1;
                            locked   <= 1'b0;
                            cnt      <= '0;
                            got_fall <= 1'b0;
                        end else begin
                            cnt <= cnt + ONE;
                            // Only the first falling edge after a rise counts.
                            if (fall_c && !got_fall) begin
                                high_lat <= cnt;
                                got_fall <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        cnt      <= '0;
                        got_fall <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
